// File: rtl/lcd_frame_capture.sv
// Captures the 160x144 2-bit LCD pixel stream into bank-switched frame stores and serves scanout reads.
// Optional macro LCD_GHOST_BLEND_EN: three banks, rd_grey blends the displayed and previous frames.
module lcd_frame_capture #(
  parameter int GAP_CLKS = 600,
  parameter int LCD_W    = 160,
  parameter int LCD_H    = 144
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on,
  input  logic       lcd_clkena,
  input  logic [1:0] lcd_data,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic       rd_valid,
  output logic [1:0] rd_pix,
  output logic [7:0] rd_grey,
  output logic       frame_done,
  output logic       frame_ready,
  output logic       sync_err
);

  localparam int NPIX = LCD_W * LCD_H;
  localparam int AW   = $clog2(NPIX);
  localparam int GW   = $clog2(GAP_CLKS + 1);
`ifdef LCD_GHOST_BLEND_EN
  localparam int NB   = 3;
`else
  localparam int NB   = 2;
`endif
  localparam int BW   = $clog2(NB);

  localparam logic [7:0]    XMAX     = 8'(LCD_W - 1);
  localparam logic [7:0]    YMAX     = 8'(LCD_H - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CLKS);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

  logic [1:0] frame_mem [NB][NPIX];

  logic [7:0]    wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [BW-1:0] wr_bank_q, wr_bank_d, disp_bank_q, disp_bank_d;
  logic          frame_ready_q, frame_ready_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;
  logic          rd_valid_q;
  logic [1:0]    rd_pix_q;
  logic [7:0]    rd_grey_q;
  logic          wr_we;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          rd_in;
  logic [1:0]    pix_disp;
  logic [7:0]    grey_rd;
`ifdef LCD_GHOST_BLEND_EN
  logic [BW-1:0] prev_bank_q, prev_bank_d;
  logic          captured_q, captured_d, prev_valid_q, prev_valid_d;
  logic [7:0]    grey_prev;
  logic [8:0]    grey_sum;
`endif

  // Shade s maps to the inverse of s replicated: 0->FF, 1->AA, 2->55, 3->00.
  function automatic logic [7:0] shade2grey(input logic [1:0] s);
    return ~{4{s}};
  endfunction

  assign wr_addr = AW'(wr_y_q) * AW'(LCD_W) + AW'(wr_x_q);
  assign rd_in   = (rd_x <= XMAX) && (rd_y <= YMAX);
  assign rd_addr = rd_in ? (AW'(rd_y) * AW'(LCD_W) + AW'(rd_x)) : '0;
  assign pix_disp = frame_mem[disp_bank_q][rd_addr];

`ifdef LCD_GHOST_BLEND_EN
  assign grey_prev = prev_valid_q ? shade2grey(frame_mem[prev_bank_q][rd_addr]) : 8'hFF;
  assign grey_sum  = {1'b0, shade2grey(pix_disp)} + {1'b0, grey_prev};
  assign grey_rd   = grey_sum[8:1];
`else
  assign grey_rd   = shade2grey(pix_disp);
`endif

  always_comb begin
    wr_x_d        = wr_x_q;
    wr_y_d        = wr_y_q;
    gap_d         = gap_q;
    wr_bank_d     = wr_bank_q;
    disp_bank_d   = disp_bank_q;
    frame_ready_d = frame_ready_q;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;
    wr_we         = 1'b0;
`ifdef LCD_GHOST_BLEND_EN
    prev_bank_d   = prev_bank_q;
    captured_d    = captured_q;
    prev_valid_d  = prev_valid_q;
`endif
    if (!lcd_on) begin
      wr_x_d        = '0;
      wr_y_d        = '0;
      gap_d         = '0;
      frame_ready_d = 1'b0;
    end else if (lcd_clkena) begin
      wr_we = 1'b1;
      gap_d = '0;
      if (wr_x_q == XMAX) begin
        wr_x_d = '0;
        if (wr_y_q == YMAX) begin
          wr_y_d        = '0;
          frame_done_d  = 1'b1;
          frame_ready_d = 1'b1;
          disp_bank_d   = wr_bank_q;
`ifdef LCD_GHOST_BLEND_EN
          wr_bank_d     = prev_bank_q;
          prev_bank_d   = disp_bank_q;
          prev_valid_d  = captured_q;
          captured_d    = 1'b1;
`else
          wr_bank_d     = disp_bank_q;
`endif
        end else begin
          wr_y_d = wr_y_q + 8'd1;
        end
      end else begin
        wr_x_d = wr_x_q + 8'd1;
      end
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
      // A vblank-length gap in the middle of a frame means we lost sync; restart at (0,0).
      if (gap_q == GAP_LAST && (wr_x_q | wr_y_q) != 8'd0) begin
        wr_x_d     = '0;
        wr_y_d     = '0;
        sync_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_we) frame_mem[wr_bank_q][wr_addr] <= lcd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_x_q        <= '0;
      wr_y_q        <= '0;
      gap_q         <= '0;
      wr_bank_q     <= BW'(0);
      disp_bank_q   <= BW'(1);
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_pix_q      <= '0;
      rd_grey_q     <= '0;
`ifdef LCD_GHOST_BLEND_EN
      prev_bank_q   <= BW'(2);
      captured_q    <= 1'b0;
      prev_valid_q  <= 1'b0;
`endif
    end else begin
      wr_x_q        <= wr_x_d;
      wr_y_q        <= wr_y_d;
      gap_q         <= gap_d;
      wr_bank_q     <= wr_bank_d;
      disp_bank_q   <= disp_bank_d;
      frame_ready_q <= frame_ready_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
      rd_valid_q    <= rd_en;
`ifdef LCD_GHOST_BLEND_EN
      prev_bank_q   <= prev_bank_d;
      captured_q    <= captured_d;
      prev_valid_q  <= prev_valid_d;
`endif
      // Read uses the bank/ready state of this cycle; a same-cycle swap shows up on the next read.
      if (rd_en) begin
        if (rd_in && frame_ready_q) begin
          rd_pix_q  <= pix_disp;
          rd_grey_q <= grey_rd;
        end else begin
          rd_pix_q  <= 2'd0;
          rd_grey_q <= 8'hFF;
        end
      end
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_pix      = rd_pix_q;
  assign rd_grey     = rd_grey_q;
  assign frame_done  = frame_done_q;
  assign frame_ready = frame_ready_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: a reference model predicts each scanout read, a queue holds
// the predictions until the DUT answers. Honours LCD_GHOST_BLEND_EN the same way as the design.
module tb_lcd_frame_capture;

  logic       clk;
  logic       reset;
  logic       lcd_on;
  logic       lcd_clkena;
  logic [1:0] lcd_data;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic       rd_valid;
  logic [1:0] rd_pix;
  logic [7:0] rd_grey;
  logic       frame_done;
  logic       frame_ready;
  logic       sync_err;

  lcd_frame_capture dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_on     (lcd_on),
    .lcd_clkena (lcd_clkena),
    .lcd_data   (lcd_data),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_pix     (rd_pix),
    .rd_grey    (rd_grey),
    .frame_done (frame_done),
    .frame_ready(frame_ready),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pix;
    logic [7:0] grey;
  } rd_exp_t;

  rd_exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int se_cnt = 0;

  // Reference model of the displayed frame (patterns, not stored pixels).
  bit m_ready = 1'b0;
  int m_disp  = 0;
`ifdef LCD_GHOST_BLEND_EN
  int m_prev        = 0;
  bit m_prev_valid  = 1'b0;
  bit m_captured    = 1'b0;
`endif

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (sync_err) se_cnt++;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1:0] shade(input int pat, input int x, input int y);
    if (pat == 4) return 2'd3;
    if (pat == 5) return 2'd0;
    return 2'((x + y + pat) & 3);
  endfunction

  function automatic logic [7:0] grey_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'hFF;
      2'd1:    return 8'hAA;
      2'd2:    return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  function automatic rd_exp_t predict(input int x, input int y);
    rd_exp_t e;
    int gsum;
    if (!m_ready || x >= 160 || y >= 144) begin
      e.pix  = 2'd0;
      e.grey = 8'hFF;
    end else begin
      e.pix = shade(m_disp, x, y);
`ifdef LCD_GHOST_BLEND_EN
      gsum = int'(grey_of(e.pix)) + (m_prev_valid ? int'(grey_of(shade(m_prev, x, y))) : 255);
`else
      gsum = 2 * int'(grey_of(e.pix));
`endif
      e.grey = 8'(gsum / 2);
    end
    return e;
  endfunction

  task automatic frame_landed(input int pat);
`ifdef LCD_GHOST_BLEND_EN
    m_prev       = m_disp;
    m_prev_valid = m_captured;
    m_captured   = 1'b1;
`endif
    m_disp  = pat;
    m_ready = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: optional pixel, optional read; the read's answer is compared right after the edge.
  task automatic step(input logic ena, input logic [1:0] d, input logic re, input int rx, input int ry);
    rd_exp_t e;
    lcd_clkena = ena;
    lcd_data   = d;
    rd_en      = re;
    rd_x       = 8'(rx);
    rd_y       = 8'(ry);
    if (re) sb.push_back(predict(rx, ry));
    tick();
    lcd_clkena = 1'b0;
    rd_en      = 1'b0;
    if (re) begin
      e = sb.pop_front();
      chk($sformatf("rd_valid(%0d,%0d)", rx, ry), 32'(rd_valid), 32'd1);
      chk($sformatf("rd_pix(%0d,%0d)", rx, ry), 32'(rd_pix), 32'(e.pix));
      chk($sformatf("rd_grey(%0d,%0d)", rx, ry), 32'(rd_grey), 32'(e.grey));
    end
  endtask

  task automatic send_frame(input int pat, input logic re, input int rx, input int ry);
    int start;
    start = fd_cnt;
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) begin
        if (x == 159 && y == 143) begin
          chk("no_early_frame_done", 32'(fd_cnt), 32'(start));
          step(1'b1, shade(pat, x, y), re, rx, ry);
        end else begin
          step(1'b1, shade(pat, x, y), 1'b0, 0, 0);
        end
      end
    end
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("frame_ready_set", 32'(frame_ready), 32'd1);
    frame_landed(pat);
    step(1'b0, 2'd0, 1'b0, 0, 0);
    chk("frame_done_width", 32'(frame_done), 32'd0);
    chk("frame_done_count", 32'(fd_cnt), 32'(start + 1));
  endtask

  initial begin
    int s0;
    int f0;
    bit found;

    reset      = 1'b1;
    lcd_on     = 1'b0;
    lcd_clkena = 1'b0;
    lcd_data   = 2'd0;
    rd_en      = 1'b0;
    rd_x       = 8'd0;
    rd_y       = 8'd0;
    tick();
    tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_pix", 32'(rd_pix), 32'd0);
    chk("rst_rd_grey", 32'(rd_grey), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    reset  = 1'b0;
    lcd_on = 1'b1;
    tick();

    // Read before any frame, then rd_valid drops with data held.
    step(1'b0, 2'd0, 1'b1, 10, 10);
    step(1'b0, 2'd0, 1'b0, 0, 0);
    chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    chk("rd_grey_held", 32'(rd_grey), 32'hFF);

    // First full frame, shade (x+y)&3.
    send_frame(0, 1'b0, 0, 0);
    step(1'b0, 2'd0, 1'b1, 5, 7);
    step(1'b0, 2'd0, 1'b1, 6, 7);
    step(1'b0, 2'd0, 1'b0, 0, 0);
    chk("rd_pix_held", 32'(rd_pix), 32'd1);
    step(1'b0, 2'd0, 1'b1, 159, 143);
    step(1'b0, 2'd0, 1'b1, 160, 0);
    step(1'b0, 2'd0, 1'b1, 0, 200);
    step(1'b0, 2'd0, 1'b1, 160, 200);

    // Partial frame followed by a vblank-length gap: discarded, display unchanged.
    f0 = fd_cnt;
    s0 = se_cnt;
    for (int i = 0; i < 2 * 160 + 10; i++) step(1'b1, shade(1, i % 160, i / 160), 1'b0, 0, 0);
    repeat (598) step(1'b0, 2'd0, 1'b0, 0, 0);
    chk("no_early_sync_err", 32'(se_cnt), 32'(s0));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b0, 2'd0, 1'b0, 0, 0);
      if (sync_err) found = 1'b1;
    end
    chk("sync_err_pulse", 32'(found), 32'd1);
    repeat (3) step(1'b0, 2'd0, 1'b0, 0, 0);
    chk("sync_err_count", 32'(se_cnt), 32'(s0 + 1));
    chk("no_frame_done_on_discard", 32'(fd_cnt), 32'(f0));
    step(1'b0, 2'd0, 1'b1, 6, 7);

    // Next frame (all 0) lands normally; a read in the swap cycle still sees the old bank.
    send_frame(5, 1'b1, 6, 7);
    step(1'b0, 2'd0, 1'b1, 6, 7);
    step(1'b0, 2'd0, 1'b1, 0, 3);

    // Drop lcd_on mid-frame, then a full fresh frame.
    for (int i = 0; i < 30; i++) step(1'b1, shade(2, i, 0), 1'b0, 0, 0);
    lcd_on  = 1'b0;
    m_ready = 1'b0;
    repeat (3) step(1'b1, 2'd3, 1'b0, 0, 0);
    chk("frame_ready_off", 32'(frame_ready), 32'd0);
    step(1'b0, 2'd0, 1'b1, 0, 3);
    lcd_on = 1'b1;
    send_frame(5, 1'b0, 0, 0);
    step(1'b0, 2'd0, 1'b1, 0, 0);
    step(1'b0, 2'd0, 1'b1, 0, 3);
    step(1'b0, 2'd0, 1'b1, 6, 7);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
